// File: rtl/byte_sus_pkg.sv
// Shared definitions for the two-lane byte unstriping / deskew block:
// FSM state encoding and the default word width and alignment marker.
package byte_sus_pkg;

  // Receive alignment state: searching, one lane locked, both lanes locked.
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SKEW = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam logic [31:0] DEF_ALIGN_SYM = 32'hBCBC_BCBC;

  // True when a strobed lane word is the alignment marker.
  function automatic logic is_marker(input logic        valid,
                                     input logic [31:0] word,
                                     input logic [31:0] sym);
    return valid && (word == sym);
  endfunction

endpackage

// File: rtl/byte_unstriping_deskew_if.sv
// Lane inputs and reassembled-stream outputs of the unstriping block.
// master drives the lanes (receive path side), slave is the deskew block.
interface byte_unstriping_deskew_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0] lane_0;
  logic             valid_0;
  logic [WIDTH-1:0] lane_1;
  logic             valid_1;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             locked;
  logic             err;

  modport master (
    output lane_0, valid_0, lane_1, valid_1,
    input  data_out, valid_out, locked, err
  );

  modport slave (
    input  lane_0, valid_0, lane_1, valid_1,
    output data_out, valid_out, locked, err
  );

endinterface

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart by the MSB; flush empties the FIFO and has priority
// over push and pop. A push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_s;
  logic             pop_s;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout   = mem_q[rd_ptr_q[AW-1:0]];
  assign push_s = push && (!full || pop) && !flush;
  assign pop_s  = pop && !empty && !flush;

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk_2f) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Pointer update with flush priority; wrap-around is native to the width.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/byte_unstriping_deskew.sv
// Two-lane byte unstriper with deskew. Each lane is buffered in its own FIFO
// once it has seen an alignment marker; when both lanes are aligned the
// FIFOs are drained alternately (lane 0 first) into a registered output.
// Markers are consumed and never stored or forwarded.
module byte_unstriping_deskew
  import byte_sus_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = 8,
  parameter int               SKEW_MAX  = 8,
  parameter logic [WIDTH-1:0] ALIGN_SYM = DEF_ALIGN_SYM
) (
  input  logic                     clk_2f,
  input  logic                     reset_L,
  byte_unstriping_deskew_if.slave  bus
);

  localparam int CW = $clog2(SKEW_MAX + 1);

  state_e           state_q;
  logic             lock0_q;
  logic             lock1_q;
  logic             turn_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_out_q;
  logic             err_q;

  logic             mk0_s;
  logic             mk1_s;
  logic             wr0_s;
  logic             wr1_s;
  logic             pop0_s;
  logic             pop1_s;
  logic             full0_s;
  logic             full1_s;
  logic             empty0_s;
  logic             empty1_s;
  logic [WIDTH-1:0] dout0_s;
  logic [WIDTH-1:0] dout1_s;
  logic             other_mk_s;
  logic             ovf_s;
  logic             timeout_s;
  logic             flush_s;

  assign mk0_s = is_marker(bus.valid_0, bus.lane_0, ALIGN_SYM);
  assign mk1_s = is_marker(bus.valid_1, bus.lane_1, ALIGN_SYM);

  // Unlocked lanes drop everything; locked lanes store only data words.
  assign wr0_s = bus.valid_0 && !mk0_s && lock0_q;
  assign wr1_s = bus.valid_1 && !mk1_s && lock1_q;

  // Only the lane whose turn it is may be popped; an empty turn lane stalls.
  assign pop0_s = (state_q == ST_RUN) && !turn_q && !empty0_s;
  assign pop1_s = (state_q == ST_RUN) &&  turn_q && !empty1_s;

  // Marker from the lane that is still waiting to lock while in SKEW.
  assign other_mk_s = lock0_q ? mk1_s : mk0_s;

  assign ovf_s     = (wr0_s && full0_s && !pop0_s) ||
                     (wr1_s && full1_s && !pop1_s);
  // A second marker on the timeout cycle still wins and completes the lock.
  assign timeout_s = (state_q == ST_SKEW) &&
                     (cnt_q == CW'(SKEW_MAX - 1)) && !other_mk_s;
  assign flush_s   = ovf_s || timeout_s;

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .push    (wr0_s),
    .pop     (pop0_s),
    .flush   (flush_s),
    .din     (bus.lane_0),
    .dout    (dout0_s),
    .full    (full0_s),
    .empty   (empty0_s)
  );

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .push    (wr1_s),
    .pop     (pop1_s),
    .flush   (flush_s),
    .din     (bus.lane_1),
    .dout    (dout1_s),
    .full    (full1_s),
    .empty   (empty1_s)
  );

  // Alignment FSM with lane locks, skew counter, turn bit and output register.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_HUNT;
      lock0_q     <= 1'b0;
      lock1_q     <= 1'b0;
      turn_q      <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      data_out_q  <= {WIDTH{1'b0}};
      valid_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (flush_s) begin
      state_q     <= ST_HUNT;
      lock0_q     <= 1'b0;
      lock1_q     <= 1'b0;
      turn_q      <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      valid_out_q <= 1'b0;
      err_q       <= 1'b1;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          valid_out_q <= 1'b0;
          cnt_q       <= {CW{1'b0}};
          if (mk0_s && mk1_s) begin
            state_q <= ST_RUN;
            lock0_q <= 1'b1;
            lock1_q <= 1'b1;
          end else if (mk0_s) begin
            state_q <= ST_SKEW;
            lock0_q <= 1'b1;
          end else if (mk1_s) begin
            state_q <= ST_SKEW;
            lock1_q <= 1'b1;
          end else begin
            state_q <= ST_HUNT;
          end
        end
        ST_SKEW: begin
          valid_out_q <= 1'b0;
          if (other_mk_s) begin
            state_q <= ST_RUN;
            lock0_q <= 1'b1;
            lock1_q <= 1'b1;
            cnt_q   <= {CW{1'b0}};
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          if (pop0_s || pop1_s) begin
            data_out_q  <= turn_q ? dout1_s : dout0_s;
            valid_out_q <= 1'b1;
            turn_q      <= ~turn_q;
          end else begin
            valid_out_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_HUNT;
          lock0_q     <= 1'b0;
          lock1_q     <= 1'b0;
          turn_q      <= 1'b0;
          cnt_q       <= {CW{1'b0}};
          valid_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.locked    = (state_q == ST_RUN);
  assign bus.err       = err_q;

endmodule
